// File: rtl/vecnormalize_cols_pkg.sv
// Fixed-point helpers shared by the matrix normalisation stages.
//   state_t    : sequencing states of the column normaliser
//   div_cycles : quotient bits (= divider cycles) for a WIDTH/FRAC format
//   MAXPOS/NEG : saturation limits of the default 16-bit word
package vecnormalize_cols_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIV,
        STORE,
        DONE
    } state_t;

    // The numerator is pre-shifted by FRAC, so the quotient carries WIDTH+FRAC bits.
    function automatic int div_cycles(input int width, input int frac);
        return width + frac;
    endfunction

    localparam int               DEF_WIDTH = 16;
    localparam logic [DEF_WIDTH-1:0] MAXPOS = {1'b0, {(DEF_WIDTH-1){1'b1}}};
    localparam logic [DEF_WIDTH-1:0] MAXNEG = {1'b1, {(DEF_WIDTH-1){1'b0}}};

endpackage

// File: rtl/fixdiv_seq.sv
// Signed sequential restoring divider for Q(WIDTH-FRAC).FRAC words.
// Computes q = (num << FRAC) / den on magnitudes, one quotient bit per cycle,
// truncating toward zero and saturating to the signed WIDTH-bit range.
//   clk, reset : clock, asynchronous active-low reset
//   load       : capture num/den and start a division (WIDTH+FRAC cycles)
//   num, den   : signed operands
//   busy       : quotient bits still being produced
//   q          : saturated signed quotient, valid once busy falls
//   dz         : the captured denominator was zero
module fixdiv_seq
    import vecnormalize_cols_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] num,
    input  logic [WIDTH-1:0] den,
    output logic             busy,
    output logic [WIDTH-1:0] q,
    output logic             dz
);

    localparam int N  = div_cycles(WIDTH, FRAC);
    localparam int CW = $clog2(N + 1);

    // Magnitude limits expressed at quotient width for the saturation test.
    localparam logic [N-1:0]     LIM_POS = N'({(WIDTH-1){1'b1}});
    localparam logic [N-1:0]     LIM_NEG = N'({1'b1, {(WIDTH-1){1'b0}}});
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] num_mag;
    logic [WIDTH-1:0] den_mag;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [N-1:0]     quo_reg;
    logic [CW-1:0]    cnt_reg;
    logic             neg_reg;
    logic             num_neg_reg;
    logic             dz_reg;
    logic [WIDTH:0]   trial;
    logic             fits;

    // Magnitude of the most negative word is 2^(WIDTH-1), still representable unsigned.
    assign num_mag = num[WIDTH-1] ? -num : num;
    assign den_mag = den[WIDTH-1] ? -den : den;

    // quo_reg starts as the shifted dividend and fills with quotient bits from the LSB.
    assign trial = {rem_reg, quo_reg[N-1]};
    assign fits  = trial >= {1'b0, dvs_reg};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_reg     <= '0;
            dvs_reg     <= '0;
            quo_reg     <= '0;
            cnt_reg     <= '0;
            neg_reg     <= 1'b0;
            num_neg_reg <= 1'b0;
            dz_reg      <= 1'b0;
        end else if (load) begin
            quo_reg     <= N'(num_mag) << FRAC;
            rem_reg     <= '0;
            dvs_reg     <= den_mag;
            neg_reg     <= num[WIDTH-1] ^ den[WIDTH-1];
            num_neg_reg <= num[WIDTH-1];
            dz_reg      <= (den == '0);
            cnt_reg     <= CW'(N);
        end else if (cnt_reg != '0) begin
            // Remainder stays below the divisor, so the difference fits WIDTH bits.
            rem_reg <= fits ? (trial[WIDTH-1:0] - dvs_reg) : trial[WIDTH-1:0];
            quo_reg <= {quo_reg[N-2:0], fits};
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    always_comb begin
        q = quo_reg[WIDTH-1:0];
        if (dz_reg) begin
            q = num_neg_reg ? SAT_NEG : SAT_POS;
        end else if (neg_reg) begin
            q = (quo_reg > LIM_NEG) ? SAT_NEG : -quo_reg[WIDTH-1:0];
        end else if (quo_reg > LIM_POS) begin
            q = SAT_POS;
        end
    end

    assign busy = (cnt_reg != '0);
    assign dz   = dz_reg;

endmodule

// File: rtl/vecnormalize_cols.sv
// Column normaliser: divides every element of a ROWS x COLS fixed-point matrix
// by its column norm using one shared sequential divider, column-major order.
//   clk, reset : clock, asynchronous active-low reset
//   start      : request, accepted only when idle
//   a, norms   : matrix and per-column norms, captured on accept
//   busy       : operation in progress
//   done       : one-cycle completion pulse, f valid from here on
//   divz       : sticky, a zero norm was met during this operation
//   f          : normalised matrix
module vecnormalize_cols
    import vecnormalize_cols_pkg::*;
#(
    parameter int ROWS  = 3,
    parameter int COLS  = 2,
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [ROWS:1][COLS:1][WIDTH-1:0]   a,
    input  logic [COLS:1][WIDTH-1:0]           norms,
    output logic                               busy,
    output logic                               done,
    output logic                               divz,
    output logic [ROWS:1][COLS:1][WIDTH-1:0]   f
);

    localparam int N   = div_cycles(WIDTH, FRAC);
    localparam int RW  = $clog2(ROWS + 1);
    localparam int CLW = $clog2(COLS + 1);
    localparam int DW  = $clog2(N);

    state_t state_reg, state_next;

    logic [ROWS:1][COLS:1][WIDTH-1:0] a_reg;
    logic [ROWS:1][COLS:1][WIDTH-1:0] f_reg;
    logic [COLS:1][WIDTH-1:0]         norms_reg;
    logic [RW-1:0]                    row_reg;
    logic [CLW-1:0]                   col_reg;
    logic [DW-1:0]                    step_reg;
    logic                             divz_reg;

    logic             div_load;
    logic             div_busy;
    logic             div_dz;
    logic [WIDTH-1:0] div_q;
    logic             last_step;
    logic             last_elem;

    assign div_load  = (state_reg == LOAD);
    assign last_step = (step_reg == DW'(N - 1));
    assign last_elem = (row_reg == RW'(ROWS)) && (col_reg == CLW'(COLS));

    fixdiv_seq #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .load  (div_load),
        .num   (a_reg[row_reg][col_reg]),
        .den   (norms_reg[col_reg]),
        .busy  (div_busy),
        .q     (div_q),
        .dz    (div_dz)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = DIV;
            DIV:     if (last_step) state_next = STORE;
            STORE:   state_next = last_elem ? DONE : LOAD;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_reg     <= '0;
            norms_reg <= '0;
            f_reg     <= '0;
            row_reg   <= '0;
            col_reg   <= '0;
            step_reg  <= '0;
            divz_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        norms_reg <= norms;
                        divz_reg  <= 1'b0;
                        row_reg   <= RW'(1);
                        col_reg   <= CLW'(1);
                    end
                end
                LOAD: step_reg <= '0;
                DIV:  step_reg <= step_reg + DW'(1);
                STORE: begin
                    f_reg[row_reg][col_reg] <= div_q;
                    if (div_dz) begin
                        divz_reg <= 1'b1;
                    end
                    // Column-major walk: rows run fastest.
                    if (row_reg == RW'(ROWS)) begin
                        row_reg <= RW'(1);
                        col_reg <= col_reg + CLW'(1);
                    end else begin
                        row_reg <= row_reg + RW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // The divider's own busy covers the DIV span; LOAD and STORE bracket it.
    assign busy = (state_reg == LOAD) || (state_reg == STORE) || div_busy;
    assign done = (state_reg == DONE);
    assign divz = divz_reg;
    assign f    = f_reg;

endmodule

// File: tb/tb_vecnormalize_cols.sv
module tb_vecnormalize_cols;

    localparam int ROWS     = 3;
    localparam int COLS     = 2;
    localparam int WIDTH    = 16;
    localparam int FRAC     = 8;
    localparam int N        = WIDTH + FRAC;
    localparam int BUSY_LEN = ROWS * COLS * (N + 2);
    localparam int LAT      = BUSY_LEN + 1;

    typedef logic [ROWS:1][COLS:1][WIDTH-1:0] mat_t;
    typedef logic [COLS:1][WIDTH-1:0]         vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    mat_t a     = '0;
    vec_t norms = '0;
    logic busy;
    logic done;
    logic divz;
    mat_t f;

    int   checks = 0;
    int   errors = 0;
    mat_t exp_f;
    logic exp_dz;
    mat_t av;
    vec_t nv;

    always #5 clk = ~clk;

    vecnormalize_cols #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .norms (norms),
        .busy  (busy),
        .done  (done),
        .divz  (divz),
        .f     (f)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the fixed-point values.
    function automatic logic [WIDTH-1:0] ref_q(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] n);
        longint sa, sn, mag;
        longint maxp, minn;
        maxp = (longint'(1) << (WIDTH - 1)) - 1;
        minn = -(longint'(1) << (WIDTH - 1));
        sa = longint'($signed(x));
        sn = longint'($signed(n));
        if (sn == 0) begin
            mag = (sa < 0) ? minn : maxp;
            return mag[WIDTH-1:0];
        end
        mag = ((sa < 0 ? -sa : sa) * (longint'(1) << FRAC)) / (sn < 0 ? -sn : sn);
        if ((sa < 0) != (sn < 0)) mag = -mag;
        if (mag > maxp) mag = maxp;
        if (mag < minn) mag = minn;
        return mag[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] rand_word();
        logic [WIDTH-1:0] w;
        case ($urandom_range(0, 3))
            0:       w = WIDTH'($urandom_range(0, 1024));
            1:       w = -WIDTH'($urandom_range(0, 1024));
            2: begin
                case ($urandom_range(0, 2))
                    0:       w = 16'h7FFF;
                    1:       w = 16'h8000;
                    default: w = 16'h0000;
                endcase
            end
            default: w = WIDTH'($urandom);
        endcase
        return w;
    endfunction

    function automatic logic [WIDTH-1:0] rand_norm();
        logic [WIDTH-1:0] w;
        case ($urandom_range(0, 5))
            0:       w = '0;
            1:       w = WIDTH'($urandom_range(1, 8));
            2:       w = -WIDTH'($urandom_range(1, 4096));
            3:       w = WIDTH'($urandom_range(256, 4096));
            default: w = WIDTH'($urandom);
        endcase
        return w;
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int r = 1; r <= ROWS; r++)
            for (int c = 1; c <= COLS; c++)
                m[r][c] = rand_word();
        return m;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int c = 1; c <= COLS; c++) v[c] = rand_norm();
        return v;
    endfunction

    // One full operation: accept, wait for done, compare against the model.
    task automatic run_op(input mat_t xa, input vec_t xn, input bit disturb,
                          input bit start_in_done, input string tag);
        int cyc;
        int bcnt;
        exp_dz = 1'b0;
        for (int r = 1; r <= ROWS; r++)
            for (int c = 1; c <= COLS; c++)
                exp_f[r][c] = ref_q(xa[r][c], xn[c]);
        for (int c = 1; c <= COLS; c++)
            if (xn[c] == '0) exp_dz = 1'b1;

        a = xa;
        norms = xn;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (disturb) begin
            a = rand_mat();
            norms = rand_vec();
        end
        cyc = 1;
        bcnt = 0;
        while (done !== 1'b1 && cyc < LAT + 50) begin
            if (busy === 1'b1) bcnt++;
            start = disturb && (cyc == 50);
            tick();
            cyc++;
        end
        start = 1'b0;
        check({tag, ".latency"}, 128'(cyc), 128'(LAT));
        check({tag, ".busy_len"}, 128'(bcnt), 128'(BUSY_LEN));
        check({tag, ".busy_at_done"}, 128'(busy), 128'(0));
        for (int r = 1; r <= ROWS; r++)
            for (int c = 1; c <= COLS; c++)
                check($sformatf("%s.f[%0d][%0d]", tag, r, c), 128'(f[r][c]), 128'(exp_f[r][c]));
        check({tag, ".divz"}, 128'(divz), 128'(exp_dz));
        $display("op %-12s latency=%0d busy_cycles=%0d divz=%0b f=%h", tag, cyc, bcnt, divz, f);
        if (start_in_done) begin
            start = 1'b1;
            tick();
            check({tag, ".start_in_done_ignored"}, 128'(busy), 128'(0));
        end else begin
            tick();
            check({tag, ".done_pulse"}, 128'(done), 128'(0));
            check({tag, ".no_queued_start"}, 128'(busy), 128'(0));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("reset.f", 128'(f), 128'(0));
        check("reset.busy", 128'(busy), 128'(0));
        check("reset.done", 128'(done), 128'(0));
        check("reset.divz", 128'(divz), 128'(0));
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Uniform matrix: 1.0 / 2.0 = 0.5
        for (int r = 1; r <= ROWS; r++)
            for (int c = 1; c <= COLS; c++)
                av[r][c] = 16'h0100;
        nv = {16'h0200, 16'h0200};
        run_op(av, nv, 1'b0, 1'b0, "uniform");
        check("uniform.f21_literal", 128'(f[2][1]), 128'(16'h0080));

        // Second start during busy and inputs changed after accept
        run_op(rand_mat(), rand_vec(), 1'b1, 1'b0, "disturb");

        // Sign and truncation toward zero
        av = '0;
        av[1][1] = 16'hFF00;
        av[2][2] = 16'h0001;
        av[3][2] = 16'hFFFF;
        nv[1] = 16'h0200;
        nv[2] = 16'h0300;
        run_op(av, nv, 1'b0, 1'b0, "sign_trunc");
        check("sign_trunc.f11_literal", 128'(f[1][1]), 128'(16'hFF80));
        check("sign_trunc.f22_literal", 128'(f[2][2]), 128'(16'h0000));
        check("sign_trunc.f32_literal", 128'(f[3][2]), 128'(16'h0000));

        // Zero norm in column 1
        av = rand_mat();
        av[1][1] = 16'h0100;
        av[2][1] = 16'hFF00;
        av[3][1] = 16'h0000;
        nv[1] = 16'h0000;
        nv[2] = rand_norm() | 16'h0001;
        run_op(av, nv, 1'b0, 1'b0, "zero_norm");
        check("zero_norm.f11_literal", 128'(f[1][1]), 128'(16'h7FFF));
        check("zero_norm.f21_literal", 128'(f[2][1]), 128'(16'h8000));
        check("zero_norm.f31_literal", 128'(f[3][1]), 128'(16'h7FFF));
        repeat (3) tick();
        check("zero_norm.divz_held", 128'(divz), 128'(1));

        // Overflow saturation, then start asserted in the DONE cycle
        av = rand_mat();
        av[1][2] = 16'h7FFF;
        nv[1] = rand_norm() | 16'h0001;
        nv[2] = 16'h0001;
        run_op(av, nv, 1'b0, 1'b1, "saturate");
        check("saturate.f12_literal", 128'(exp_f[1][2]), 128'(16'h7FFF));

        // Accepted one cycle after DONE (start still high)
        run_op(rand_mat(), rand_vec(), 1'b0, 1'b0, "after_done");

        for (int i = 0; i < 8; i++)
            run_op(rand_mat(), rand_vec(), 1'b0, 1'b0, $sformatf("random%0d", i));

        // Reset asserted mid-operation
        av = rand_mat();
        nv[1] = 16'h0000;
        nv[2] = 16'h0100;
        a = av;
        norms = nv;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (49) tick();
        check("abort.divz_before", 128'(divz), 128'(1));
        #2;
        reset = 1'b0;
        #1;
        check("abort.f", 128'(f), 128'(0));
        check("abort.busy", 128'(busy), 128'(0));
        check("abort.done", 128'(done), 128'(0));
        check("abort.divz", 128'(divz), 128'(0));
        $display("op abort       reset applied at cycle 50 f=%h busy=%0b divz=%0b", f, busy, divz);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_op(rand_mat(), rand_vec(), 1'b0, 1'b0, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
